// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: reset vector and fetch FSM encoding.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/f_fetch_buf.sv
// Fetch-side buffers: a word that arrived while D was stalled, and a redirect
// address captured when D drained before the next fetch completed.
module f_fetch_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hold_load,
    input  logic [31:0] imem_rdata,
    input  logic        pend_set,
    input  logic        pend_clr,
    input  logic [31:0] npc,
    output logic [31:0] hold_q,
    output logic [31:0] npc_q,
    output logic        npc_pend
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q   <= 32'd0;
            npc_q    <= 32'd0;
            npc_pend <= 1'b0;
        end else begin
            if (hold_load) begin
                hold_q <= imem_rdata;
            end
            // Set and clear never coincide: set needs no delivery, clear needs one.
            if (pend_set) begin
                npc_q    <= npc;
                npc_pend <= 1'b1;
            end else if (pend_clr) begin
                npc_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: PC register, single-outstanding imem req/ack handshake and the
// F/D pipeline register feeding decode.
module f_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] npc,
    input  logic        d_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_pc,
    output logic        fd_valid,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_instr
);

    fetch_state_t state_reg;

    logic        deliver;
    logic        accept;
    logic        bubble;
    logic        hold_load;
    logic [31:0] word;
    logic [31:0] hold_q;
    logic [31:0] npc_q;
    logic        npc_pend;

    assign deliver   = ((state_reg == S_REQ) && imem_ack) || (state_reg == S_HOLD);
    assign accept    = deliver && !d_stall;
    assign bubble    = !deliver && !d_stall;
    assign hold_load = (state_reg == S_REQ) && imem_ack && d_stall;
    assign word      = (state_reg == S_HOLD) ? hold_q : imem_rdata;
    assign imem_addr = F_pc;

    // A valid D instruction leaving with nothing behind it may be a branch
    // whose redirect must survive until the delay slot arrives.
    f_fetch_buf u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .hold_load  (hold_load),
        .imem_rdata (imem_rdata),
        .pend_set   (bubble && fd_valid),
        .pend_clr   (accept),
        .npc        (npc),
        .hold_q     (hold_q),
        .npc_q      (npc_q),
        .npc_pend   (npc_pend)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            imem_req  <= 1'b0;
            F_pc      <= RESET_PC;
            fd_valid  <= 1'b0;
            fd_pc     <= 32'd0;
            fd_instr  <= 32'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_reg <= S_REQ;
                    imem_req  <= 1'b1;
                end
                S_REQ: begin
                    // On an accepted ack we stay in S_REQ with the new PC.
                    if (imem_ack && d_stall) begin
                        state_reg <= S_HOLD;
                        imem_req  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!d_stall) begin
                        state_reg <= S_REQ;
                        imem_req  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    imem_req  <= 1'b0;
                end
            endcase

            if (accept) begin
                fd_valid <= 1'b1;
                fd_pc    <= F_pc;
                fd_instr <= word;
                F_pc     <= npc_pend ? npc_q : npc;
            end else if (bubble) begin
                fd_valid <= 1'b0;
                fd_instr <= 32'd0;
            end
        end
    end

endmodule

// File: doc/f_fetch_unit.md
# f_fetch_unit

Fetch stage of the 5-stage MIPS pipeline.
- Holds the PC register and issues one instruction-memory request at a time over a req/ack handshake.
- Loads the fetched word into the F/D pipeline register.
- Takes its next address from the D-stage `npc` output. With the branch delay slot, that address reaches fetch only once the branch is already in D.
- Exports `F_pc` and `fd_pc` back to D-stage next-PC logic; the memory may take several cycles per ack.

## Interface
- `RESET_PC`, 32'h0000_3000, first fetch address after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `npc` in 32: next PC from D-stage next-PC logic. It is computed from `F_pc`, `fd_pc` and `fd_instr`.
- `d_stall` in 1: D stage cannot accept a new instruction this cycle.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: word address; equals `F_pc`.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle. Exactly one ack per request; it may arrive in the same cycle as the request.
- `imem_rdata` in 32: instruction word; valid only when `imem_ack` is high.
- `F_pc` out 32: PC register, the address currently being fetched or held.
- `fd_valid` out 1: F/D register holds a real instruction.
- `fd_pc` out 32: PC of the instruction in D.
- `fd_instr` out 32: instruction in D. Reads 0 (nop) whenever `fd_valid` is 0.

## Operation
- States:
  - S_IDLE: reset state.
  - S_REQ: request outstanding.
  - S_HOLD: word received, waiting for D to accept it.
- S_IDLE always moves to S_REQ on the next cycle.
- `imem_req` is 1 exactly when the state is S_REQ. `imem_addr` is `F_pc` and stays stable until the ack.
- `deliver` is (S_REQ and `imem_ack`) or S_HOLD. The delivered word is `imem_rdata` in S_REQ and `hold_q` in S_HOLD.
- `deliver` and not `d_stall`:
  - F/D register loads {`F_pc`, word}; `fd_valid` is set to 1.
  - `F_pc` loads `npc_q` if `npc_pend` is set, otherwise `npc`; `npc_pend` clears.
  - Next state is S_REQ.
- S_REQ, `imem_ack` and `d_stall`:
  - `hold_q` loads `imem_rdata`; next state is S_HOLD.
  - `F_pc` and F/D are unchanged.
- No `deliver` and not `d_stall`:
  - F/D loads a bubble: `fd_valid` is 0, `fd_instr` is 0, `fd_pc` keeps its value.
  - If `fd_valid` was 1, the D instruction is leaving with no replacement. `npc_q` loads `npc` and `npc_pend` is set, so a redirect from a branch or jump is not lost.
- `d_stall` high: F/D, `F_pc`, `npc_q` and `npc_pend` all hold. An ack arriving in S_REQ still goes to `hold_q`.
- `npc_pend` never sets while it is already set: `fd_valid` is 0 after the capture, so the capture condition cannot recur before it clears.
- No alignment checks; the two low address bits are passed through unchanged.

## Timing
- Reset values:
  - State S_IDLE; `F_pc` = `RESET_PC`; `imem_req` 0.
  - `fd_valid` 0, `fd_pc` 0, `fd_instr` 0.
  - `npc_pend` 0, `npc_q` 0, `hold_q` 0.
- First request in the first cycle after `reset_n` rises.
- Zero-wait memory (ack in the same cycle as the request) and no stall: one instruction per cycle.
  - `fd_*` shows the instruction fetched at `F_pc` one cycle after its ack.
  - `F_pc` advances in the same edge.
- An ack arriving N cycles after the request gives N bubbles in D.
- Ack and `d_stall` in the same cycle: the word is accepted by the buffer. The memory is never made to hold its data.
- Reset asserted mid-request: everything returns to reset values immediately. The memory shares `reset_n` and drops any outstanding request, so no ack arrives for a request made before reset.

## Structure
- Shared package `mips_pkg`:
  - `RESET_PC` default.
  - State encoding: S_IDLE=2'd0, S_REQ=2'd1, S_HOLD=2'd2.
- One sub-module, `f_fetch_buf`: holds `hold_q`, `npc_q` and `npc_pend` with their load and clear logic.
- The top level holds the state machine, the PC register and the F/D register.

## Test plan
- Reset release, zero-wait memory, `npc` = `F_pc`+4:
  - `imem_addr` is 0x3000, 0x3004, 0x3008 on consecutive cycles.
  - `fd_pc` is 0x3000 one cycle after the first ack.
- Ack at 0x3004 while `d_stall` is high for 2 cycles:
  - State S_HOLD; `F_pc` stays 0x3004; F/D unchanged.
  - When `d_stall` falls, `fd_instr` equals the buffered word and the next request goes to `npc`.
- beq at 0x3000 taken to 0x3040, memory with 3-cycle ack latency:
  - The branch leaves D before the delay slot at 0x3004 arrives, so `npc_pend` is set with `npc_q` = 0x3040.
  - After the delay slot is delivered, `imem_addr` is 0x3040.
- jal in D with zero-wait memory, target 0x0000_3100:
  - Delay slot 0x3004 is delivered, then `imem_addr` is 0x3100.
- Assert `reset_n` while a 3-cycle request is outstanding:
  - `imem_req` drops immediately; `fd_valid` is 0.
  - Next request goes to 0x3000 one cycle after release.
